// File: rtl/mod_instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mod_instr_fetch_pkg;

    localparam int PC_INC     = 4;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // RUN: normal fetch. DRAIN: stale responses from before a redirect are still in flight.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifetch_state_t;

endpackage

// File: rtl/mod_instr_fetch_if.sv
// Bundles the imem request/response, redirect and decode handshake signals of the fetch unit.
// Latency: n/a (wiring only).
// Backpressure: imem_req_ready and instr_ready; imem responses are never backpressured.
interface mod_instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] pc_out;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc,
        output instr_valid, instr, opcode, funct, pc_out,
        input  instr_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc,
        input  instr_valid, instr, opcode, funct, pc_out,
        output instr_ready
    );
endinterface

// File: rtl/mod_ifetch_fifo.sv
// Synchronous FIFO holding fetched {instr, pc} entries; head is presented combinationally.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: reports full/count; push when full is ignored, flush beats push and pop.
module mod_ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = ram[rd_ptr_q];

    // Pointer and occupancy update; flush wins over everything else.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ram[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/mod_instr_fetch.sv
// Instruction fetch: in-order imem reads, buffered {instr, pc} to decode, redirect with stale-response discard.
// Latency: imem response to instr_valid is 1 cycle; first request issues 1 cycle after reset release.
// Backpressure: credits cap buffered+in-flight at DEPTH; instr_ready stalls fetch. Optional IFETCH_STATS_EN adds counters.
module mod_instr_fetch
    import mod_instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    mod_instr_fetch_if.master   bus
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } ibuf_ent_t;

    ifetch_state_t     state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              live_q, live_d;

    logic              push, pop, flush, full, empty;
    logic [CW-1:0]     count;
    ibuf_ent_t         push_ent, head_ent;
    logic [$bits(ibuf_ent_t)-1:0] head_raw;

    logic              credit_ok, req_vld, req_fire, rsp;
    logic [ADDR_W-1:0] target_pc;

    mod_ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ibuf_ent_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_raw),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign head_ent = ibuf_ent_t'(head_raw);

    // Next-state logic: credits, request/response bookkeeping, redirect and FSM.
    always_comb begin
        credit_ok = ({1'b0, count} + {1'b0, outst_q}) < (CW + 1)'(DEPTH);
        req_vld   = live_q && !bus.redirect && credit_ok;
        req_fire  = req_vld && bus.imem_req_ready;
        rsp       = bus.imem_rsp_valid;
        target_pc = bus.redirect_pc & ~ADDR_W'(3);

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        state_d    = state_q;
        live_d     = 1'b1;
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp);
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        push_ent   = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};

        if (bus.redirect) begin
            flush      = 1'b1;
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            // Every request still in flight after this cycle belongs to the old path.
            // outst_q already includes any earlier stale ones, so this also covers
            // back-to-back redirects without double counting.
            discard_d  = outst_q - CW'(rsp);
            state_d    = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
            end
            if (rsp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + ADDR_W'(PC_INC);
                end
            end
            pop = !empty && bus.instr_ready;
            if (state_q == DRAIN && discard_d == '0) begin
                state_d = RUN;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            live_q     <= live_d;
        end
    end

    // When empty, pc_out shows the PC the next returned word will carry.
    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = !empty;
    assign bus.instr          = empty ? '0 : head_ent.instr;
    assign bus.pc_out         = empty ? rsp_pc_q : head_ent.pc;
    assign bus.opcode         = bus.instr[OPCODE_MSB:OPCODE_LSB];
    assign bus.funct          = bus.instr[FUNCT_MSB:FUNCT_LSB];

    // Credits must keep the buffer from ever overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

`ifdef IFETCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: empty cycles while running, and redirects.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (empty && state_q == RUN && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.redirect && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
